alu_serial_tx: RTL and testbench

ALU_SERIAL_TX -- requirements
Module: alu_serial_tx

---
 rtl/alu_serial_pkg.sv | 17 +
 rtl/parity_xnor4.sv | 21 ++
 rtl/alu_serial_tx.sv | 157 +++++++++++++++
 tb/tb_alu_serial_tx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_serial_pkg.sv
// Shared types and constants for the ALU serial transmitter.
// Frame lengths cover both builds (with and without the STOP bit).
package alu_serial_pkg;

    localparam int DATA_W         = 4;
    localparam int FRAME_LEN      = 6;
    localparam int FRAME_LEN_STOP = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/parity_xnor4.sv
// Balanced XOR tree over the 4-bit word; ODD=1 inverts the root.
// The result is the parity bit that makes the frame's total count of 1s odd.
module parity_xnor4
    import alu_serial_pkg::*;
#(
    parameter bit ODD = 1'b1
) (
    input  logic [DATA_W-1:0] data_i,
    output logic              parity_o
);

    logic x01;
    logic x23;
    logic x_all;

    assign x01      = data_i[0] ^ data_i[1];
    assign x23      = data_i[2] ^ data_i[3];
    assign x_all    = x01 ^ x23;
    assign parity_o = ODD ? ~x_all : x_all;

endmodule

// File: rtl/alu_serial_tx.sv
// Serialises 4-bit ALU words as start, 4 data bits LSB first, and parity.
// Defining ALU_SERIAL_TX_STOP_EN appends a one-cycle stop bit (SDO=1).
module alu_serial_tx
    import alu_serial_pkg::*;
#(
    parameter bit PARITY_ODD = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              SDO,
    output logic              SFRAME,
    output logic              DONE
);

    // Handshake: a word moves on a rising edge where DIN_VALID and DIN_READY
    // are both high; DIN is captured on that edge and never sampled again.

    tx_state_e         state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              sdo_q, sdo_d;
    logic              sframe_q, sframe_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              xfer;
    logic              parity_bit;

    parity_xnor4 #(
        .ODD (PARITY_ODD)
    ) u_parity (
        .data_i   (word_q),
        .parity_o (parity_bit)
    );

    assign xfer = DIN_VALID && ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d = ST_START;
                    word_d  = DIN;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
                cnt_d   = 2'd0;
            end
            ST_DATA: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
`ifdef ALU_SERIAL_TX_STOP_EN
                state_d = ST_STOP;
`else
                if (xfer) begin
                    state_d = ST_START;
                    word_d  = DIN;
                end else begin
                    state_d = ST_IDLE;
                end
`endif
            end
`ifdef ALU_SERIAL_TX_STOP_EN
            ST_STOP: begin
                if (xfer) begin
                    state_d = ST_START;
                    word_d  = DIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (RST) begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
            word_d  = '0;
        end
    end

    // Outputs are decoded from the next state so they can be registered
    // while still lining up with the state they describe.
    always_comb begin
        sdo_d    = 1'b1;
        sframe_d = 1'b0;
        done_d   = 1'b0;
        ready_d  = 1'b0;

        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
            end
            ST_START: begin
                sdo_d    = 1'b0;
                sframe_d = 1'b1;
            end
            ST_DATA: begin
                sdo_d    = word_d[cnt_d];
                sframe_d = 1'b1;
            end
            ST_PARITY: begin
                sdo_d    = parity_bit;
                sframe_d = 1'b1;
`ifndef ALU_SERIAL_TX_STOP_EN
                done_d   = 1'b1;
                ready_d  = 1'b1;
`endif
            end
`ifdef ALU_SERIAL_TX_STOP_EN
            ST_STOP: begin
                sdo_d    = 1'b1;
                sframe_d = 1'b1;
                done_d   = 1'b1;
                ready_d  = 1'b1;
            end
`endif
            default: begin
                sdo_d = 1'b1;
            end
        endcase

        if (RST) begin
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        word_q   <= word_d;
        sdo_q    <= sdo_d;
        sframe_q <= sframe_d;
        done_q   <= done_d;
        ready_q  <= ready_d;
    end

    assign DIN_READY = ready_q;
    assign SDO       = sdo_q;
    assign SFRAME    = sframe_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_alu_serial_tx.sv
// Directed bench for alu_serial_tx: odd- and even-parity instances share stimulus.
// Frame expectations are hand-written bit vectors, bit i = SDO in frame cycle i.
module tb_alu_serial_tx;
    import alu_serial_pkg::*;

`ifdef ALU_SERIAL_TX_STOP_EN
    localparam int FL = FRAME_LEN_STOP;
`else
    localparam int FL = FRAME_LEN;
`endif

    logic       CLK;
    logic       RST;
    logic [3:0] DIN;
    logic       DIN_VALID;
    logic       rdy_o, sdo_o, sfr_o, done_o;
    logic       rdy_e, sdo_e, sfr_e, done_e;

    int n_vec;
    int n_err;

    alu_serial_tx #(.PARITY_ODD(1'b1)) dut (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_READY(rdy_o), .SDO(sdo_o), .SFRAME(sfr_o), .DONE(done_o)
    );

    alu_serial_tx #(.PARITY_ODD(1'b0)) dut_even (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_READY(rdy_e), .SDO(sdo_e), .SFRAME(sfr_e), .DONE(done_e)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        DIN_VALID = 1'b0;
        DIN = 4'h0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++;
            if ({sdo_o, sfr_o, done_o, rdy_o} !== 4'b1000) begin
                n_err++;
                $display("FAIL reset_outputs cyc%0d got %b exp 1000", c, {sdo_o, sfr_o, done_o, rdy_o});
            end
        end
        RST = 1'b0;
        tick();
        n_vec++;
        if ({sdo_o, sfr_o, done_o, rdy_o} !== 4'b1001) begin
            n_err++;
            $display("FAIL reset_release got %b exp 1001", {sdo_o, sfr_o, done_o, rdy_o});
        end
    endtask

    task automatic test_frame(input string name, input logic [3:0] word,
                              input logic [6:0] exp_odd, input logic [6:0] exp_even);
        DIN = word;
        DIN_VALID = 1'b1;
        tick();
        DIN_VALID = 1'b0;
        DIN = ~word;
        for (int i = 0; i < FL; i++) begin
            n_vec++;
            if (sdo_o !== exp_odd[i] || sdo_e !== exp_even[i]) begin
                n_err++;
                $display("FAIL %s sdo cyc%0d got %b/%b exp %b/%b", name, i, sdo_o, sdo_e, exp_odd[i], exp_even[i]);
            end
            n_vec++;
            if (sfr_o !== 1'b1 || done_o !== (i == FL - 1) || rdy_o !== (i == FL - 1)) begin
                n_err++;
                $display("FAIL %s ctrl cyc%0d got sframe=%b done=%b ready=%b exp 1 %b %b",
                         name, i, sfr_o, done_o, rdy_o, i == FL - 1, i == FL - 1);
            end
            DIN = 4'($urandom_range(0, 15));
            tick();
        end
        n_vec++;
        if ({sdo_o, sfr_o, done_o, rdy_o} !== 4'b1001) begin
            n_err++;
            $display("FAIL %s idle_after got %b exp 1001", name, {sdo_o, sfr_o, done_o, rdy_o});
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] f1_o, f1_e, f2_o, f2_e;
        logic       eo, ee;
        int         p;
        f1_o = 7'b1101010;
        f1_e = 7'b1001010;
        f2_o = 7'b1011100;
        f2_e = 7'b1111100;
        DIN = 4'b0101;
        DIN_VALID = 1'b1;
        tick();
        DIN = 4'b1110;
        for (int i = 0; i < 2 * FL; i++) begin
            p  = (i < FL) ? i : i - FL;
            eo = (i < FL) ? f1_o[p] : f2_o[p];
            ee = (i < FL) ? f1_e[p] : f2_e[p];
            n_vec++;
            if (sdo_o !== eo || sdo_e !== ee) begin
                n_err++;
                $display("FAIL b2b sdo cyc%0d got %b/%b exp %b/%b", i, sdo_o, sdo_e, eo, ee);
            end
            n_vec++;
            if (sfr_o !== 1'b1 || done_o !== (p == FL - 1)) begin
                n_err++;
                $display("FAIL b2b ctrl cyc%0d got sframe=%b done=%b exp 1 %b", i, sfr_o, done_o, p == FL - 1);
            end
            if (i == FL) DIN_VALID = 1'b0;
            tick();
        end
        n_vec++;
        if (sfr_o !== 1'b0 || sdo_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b idle_after got sframe=%b sdo=%b exp 0 1", sfr_o, sdo_o);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] pre;
        pre = 4'b1100;
        DIN = 4'b0110;
        DIN_VALID = 1'b1;
        tick();
        DIN_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (sdo_o !== pre[i]) begin
                n_err++;
                $display("FAIL midrst pre sdo cyc%0d got %b exp %b", i, sdo_o, pre[i]);
            end
            if (i < 3) tick();
        end
        RST = 1'b1;
        tick();
        n_vec++;
        if ({sdo_o, sfr_o, done_o, rdy_o} !== 4'b1000) begin
            n_err++;
            $display("FAIL midrst in_reset got %b exp 1000", {sdo_o, sfr_o, done_o, rdy_o});
        end
        RST = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_vec++;
            if ({sdo_o, sfr_o, done_o, rdy_o} !== 4'b1001) begin
                n_err++;
                $display("FAIL midrst after cyc%0d got %b exp 1001", k, {sdo_o, sfr_o, done_o, rdy_o});
            end
        end
        test_frame("midrst_new", 4'b1001, 7'b1110010, 7'b1010010);
    endtask

    task automatic test_reset_priority();
        RST = 1'b1;
        DIN = 4'b1010;
        DIN_VALID = 1'b1;
        tick();
        RST = 1'b0;
        DIN_VALID = 1'b0;
        n_vec++;
        if (sfr_o !== 1'b0 || rdy_o !== 1'b0) begin
            n_err++;
            $display("FAIL rstprio in_reset got sframe=%b ready=%b exp 0 0", sfr_o, rdy_o);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (sfr_o !== 1'b0 || sdo_o !== 1'b1 || rdy_o !== 1'b1) begin
                n_err++;
                $display("FAIL rstprio dropped cyc%0d got sframe=%b sdo=%b ready=%b exp 0 1 1",
                         k, sfr_o, sdo_o, rdy_o);
            end
        end
    endtask

`ifdef ALU_SERIAL_TX_STOP_EN
    task automatic test_stop();
        test_frame("stop_1111", 4'b1111, 7'b1111110, 7'b1011110);
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        RST = 1'b1;
        DIN = 4'h0;
        DIN_VALID = 1'b0;
        test_reset();
        test_frame("frame_1011", 4'b1011, 7'b1010110, 7'b1110110);
        test_frame("parity_0000", 4'b0000, 7'b1100000, 7'b1000000);
        test_frame("frame_0011", 4'b0011, 7'b1100110, 7'b1000110);
        test_back_to_back();
        test_reset_mid_frame();
        test_reset_priority();
`ifdef ALU_SERIAL_TX_STOP_EN
        test_stop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
